// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg -- shared definitions for the MC pipeline controller.
//   * default width/count constants for mc_pipe_ctrl parameters
//   * calc and core FSM state encodings
//   * small helpers (select width, saturating 8-bit increment)
// ---------------------------------------------------------------------------
package mc_pkg;

    localparam int DEF_EXP_N  = 3;
    localparam int DEF_CORE_N = 2;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 18;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_RUN   = 2'd1,
        C_READY = 2'd2
    } calc_state_e;

    typedef enum logic {
        K_IDLE = 1'b0,
        K_RUN  = 1'b1
    } core_state_e;

    // Width of the lane select counter; a single lane still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/mc_sticky_all.sv
// ---------------------------------------------------------------------------
// mc_sticky_all -- collects one-cycle done pulses from N sources into a
// sticky vector and flags when every source has reported.
//   CLK      : clock, rising edge
//   iRst_n   : synchronous active-low reset
//   iClr     : synchronous clear of the collected vector (wins over iEn)
//   iEn      : collection window; pulses outside it are ignored
//   iDone    : per-source done pulses
//   oAllDone : combinational, 1 when (collected | iDone) is all-ones while
//              iEn is high, so the last pulse is recognised on its own cycle
// ---------------------------------------------------------------------------
module mc_sticky_all #(
    parameter int N = 1
) (
    input  logic         CLK,
    input  logic         iRst_n,
    input  logic         iClr,
    input  logic         iEn,
    input  logic [N-1:0] iDone,
    output logic         oAllDone
);

    logic [N-1:0] sticky_r;
    logic [N-1:0] merged_s;

    // Merge history with this cycle's pulses and test for completion.
    always_comb begin
        merged_s = sticky_r | iDone;
        if (iEn) begin
            oAllDone = &merged_s;
        end else begin
            oAllDone = 1'b0;
        end
    end

    // Sticky collection register; clear has priority over collection.
    always_ff @(posedge CLK) begin
        if (!iRst_n) begin
            sticky_r <= {N{1'b0}};
        end else if (iClr) begin
            sticky_r <= {N{1'b0}};
        end else if (iEn) begin
            sticky_r <= merged_s;
        end else begin
            sticky_r <= sticky_r;
        end
    end

endmodule

// File: rtl/mc_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// mc_pipe_ctrl -- two-stage pipeline controller: an exponent-calc stage
// (EXP_N lanes) feeding a bank of CORE_N MC cores through a double buffer.
//   CLK, iRst_n          : clock / synchronous active-low reset
//   iOptValid            : new option request (pulse)
//   iLaneAddr/Data/Valid : packed per-lane outputs of the exponent lanes
//   iLaneDone, iCoreDone : per-lane / per-core done pulses
//   oStartCalc/oStartCores : one-cycle start pulses
//   oBank                : double-buffer select, toggles at each core launch
//   oBusyCalc/oBusyCores : stage busy flags
//   oAddr/oData/oValid   : registered round-robin lane mux
//   oOverrun             : request arrived while one was already pending
// Optional: define MC_PIPE_STATS_EN to add oOptCount (core launches, wraps)
// and oOverrunCount (overruns, saturates at 255).
// ---------------------------------------------------------------------------
module mc_pipe_ctrl
    import mc_pkg::*;
#(
    parameter int EXP_N  = DEF_EXP_N,
    parameter int CORE_N = DEF_CORE_N,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    CLK,
    input  logic                    iRst_n,
    input  logic                    iOptValid,
    input  logic [EXP_N*ADDR_W-1:0] iLaneAddr,
    input  logic [EXP_N*DATA_W-1:0] iLaneData,
    input  logic [EXP_N-1:0]        iLaneValid,
    input  logic [EXP_N-1:0]        iLaneDone,
    input  logic [CORE_N-1:0]       iCoreDone,
    output logic                    oStartCalc,
    output logic                    oStartCores,
    output logic                    oBank,
    output logic                    oBusyCalc,
    output logic                    oBusyCores,
    output logic [ADDR_W-1:0]       oAddr,
    output logic [DATA_W-1:0]       oData,
    output logic                    oValid,
    output logic                    oOverrun
`ifdef MC_PIPE_STATS_EN
    ,
    output logic [15:0]             oOptCount,
    output logic [7:0]              oOverrunCount
`endif
);

    localparam int SEL_W = sel_width(EXP_N);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(EXP_N - 1);

    calc_state_e       calcState_r, calcNext_s;
    core_state_e       coreState_r, coreNext_s;
    logic              pending_r, pendingNext_s;
    logic [SEL_W-1:0]  sel_r, selNext_s;
    logic              calcRun_s, coreRun_s, coreClr_s;
    logic              laneAll_s, coreAll_s;
    logic              calcGo_s, launch_s;
    int                laneIdx_s;
    logic              bankNext_s, busyCalcNext_s, busyCoresNext_s;
    logic              validNext_s, overrunNext_s;
    logic [ADDR_W-1:0] addrNext_s;
    logic [DATA_W-1:0] dataNext_s;

    // Handoff conditions. A core group finishing on this very edge counts as
    // free, so a waiting result launches on the cycle right after the last
    // core done instead of idling one cycle in K_IDLE.
    always_comb begin
        calcRun_s = (calcState_r == C_RUN);
        coreRun_s = (coreState_r == K_RUN);
        calcGo_s  = (calcState_r == C_IDLE) && pending_r;
        launch_s  = (calcState_r == C_READY) && ((coreState_r == K_IDLE) || coreAll_s);
        coreClr_s = !coreRun_s || launch_s;
    end

    mc_sticky_all #(.N(EXP_N)) u_lane_done (
        .CLK      (CLK),
        .iRst_n   (iRst_n),
        .iClr     (!calcRun_s),
        .iEn      (calcRun_s),
        .iDone    (iLaneDone),
        .oAllDone (laneAll_s)
    );

    mc_sticky_all #(.N(CORE_N)) u_core_done (
        .CLK      (CLK),
        .iRst_n   (iRst_n),
        .iClr     (coreClr_s),
        .iEn      (coreRun_s),
        .iDone    (iCoreDone),
        .oAllDone (coreAll_s)
    );

    // State, pending flag and lane-select registers.
    always_ff @(posedge CLK) begin
        if (!iRst_n) begin
            calcState_r <= C_IDLE;
            coreState_r <= K_IDLE;
            pending_r   <= 1'b0;
            sel_r       <= {SEL_W{1'b0}};
        end else begin
            calcState_r <= calcNext_s;
            coreState_r <= coreNext_s;
            pending_r   <= pendingNext_s;
            sel_r       <= selNext_s;
        end
    end

    // Next-state logic for both FSMs, the pending flag and the lane select.
    always_comb begin
        calcNext_s = calcState_r;
        case (calcState_r)
            C_IDLE:  if (calcGo_s)  calcNext_s = C_RUN;   else calcNext_s = C_IDLE;
            C_RUN:   if (laneAll_s) calcNext_s = C_READY; else calcNext_s = C_RUN;
            C_READY: if (launch_s)  calcNext_s = C_IDLE;  else calcNext_s = C_READY;
            default: calcNext_s = C_IDLE;
        endcase

        coreNext_s = coreState_r;
        case (coreState_r)
            K_IDLE:  if (launch_s) coreNext_s = K_RUN; else coreNext_s = K_IDLE;
            K_RUN: begin
                if (launch_s) begin
                    coreNext_s = K_RUN;
                end else if (coreAll_s) begin
                    coreNext_s = K_IDLE;
                end else begin
                    coreNext_s = K_RUN;
                end
            end
            default: coreNext_s = K_IDLE;
        endcase

        // A request arriving on the start edge keeps the flag set.
        if (iOptValid) begin
            pendingNext_s = 1'b1;
        end else if (calcGo_s) begin
            pendingNext_s = 1'b0;
        end else begin
            pendingNext_s = pending_r;
        end

        // Select only advances while staying in C_RUN, so every run starts at lane 0.
        if (calcRun_s && (calcNext_s == C_RUN)) begin
            if (sel_r == SEL_LAST) begin
                selNext_s = {SEL_W{1'b0}};
            end else begin
                selNext_s = sel_r + SEL_W'(1);
            end
        end else begin
            selNext_s = {SEL_W{1'b0}};
        end
    end

    // Next values of the registered outputs, including the lane mux.
    always_comb begin
        laneIdx_s       = int'(sel_r);
        addrNext_s      = iLaneAddr[laneIdx_s*ADDR_W +: ADDR_W];
        dataNext_s      = iLaneData[laneIdx_s*DATA_W +: DATA_W];
        validNext_s     = iLaneValid[laneIdx_s] && calcRun_s;
        busyCalcNext_s  = (calcNext_s == C_RUN);
        busyCoresNext_s = (coreNext_s == K_RUN);
        overrunNext_s   = iOptValid && pending_r;
        if (launch_s) begin
            bankNext_s = ~oBank;
        end else begin
            bankNext_s = oBank;
        end
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (!iRst_n) begin
            oStartCalc  <= 1'b0;
            oStartCores <= 1'b0;
            oBank       <= 1'b0;
            oBusyCalc   <= 1'b0;
            oBusyCores  <= 1'b0;
            oAddr       <= {ADDR_W{1'b0}};
            oData       <= {DATA_W{1'b0}};
            oValid      <= 1'b0;
            oOverrun    <= 1'b0;
        end else begin
            oStartCalc  <= calcGo_s;
            oStartCores <= launch_s;
            oBank       <= bankNext_s;
            oBusyCalc   <= busyCalcNext_s;
            oBusyCores  <= busyCoresNext_s;
            oAddr       <= addrNext_s;
            oData       <= dataNext_s;
            oValid      <= validNext_s;
            oOverrun    <= overrunNext_s;
        end
    end

`ifdef MC_PIPE_STATS_EN
    // Statistics: launches wrap, overruns saturate.
    always_ff @(posedge CLK) begin
        if (!iRst_n) begin
            oOptCount     <= 16'd0;
            oOverrunCount <= 8'd0;
        end else begin
            if (launch_s) begin
                oOptCount <= oOptCount + 16'd1;
            end else begin
                oOptCount <= oOptCount;
            end
            if (overrunNext_s) begin
                oOverrunCount <= sat_inc8(oOverrunCount);
            end else begin
                oOverrunCount <= oOverrunCount;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_pipe_ctrl -- directed self-checking bench for mc_pipe_ctrl.
// Main instance uses default parameters; a second instance covers EXP_N=1.
// Inputs change 1 time unit after a rising edge; outputs are read there too,
// so each read reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_mc_pipe_ctrl;

    localparam int EXP_N  = 3;
    localparam int CORE_N = 2;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 18;

    logic                    CLK = 1'b0;
    logic                    iRst_n;
    logic                    iOptValid;
    logic [EXP_N*ADDR_W-1:0] iLaneAddr;
    logic [EXP_N*DATA_W-1:0] iLaneData;
    logic [EXP_N-1:0]        iLaneValid;
    logic [EXP_N-1:0]        iLaneDone;
    logic [CORE_N-1:0]       iCoreDone;
    logic                    oStartCalc, oStartCores, oBank, oBusyCalc, oBusyCores;
    logic [ADDR_W-1:0]       oAddr;
    logic [DATA_W-1:0]       oData;
    logic                    oValid, oOverrun;

    // single-lane instance signals
    logic                    s1Opt;
    logic [ADDR_W-1:0]       s1Addr;
    logic [DATA_W-1:0]       s1Data;
    logic [0:0]              s1Valid, s1Done, s1CoreDone;
    logic                    s1oStartCalc, s1oStartCores, s1oBank, s1oBusyCalc, s1oBusyCores;
    logic [ADDR_W-1:0]       s1oAddr;
    logic [DATA_W-1:0]       s1oData;
    logic                    s1oValid, s1oOverrun;

`ifdef MC_PIPE_STATS_EN
    logic [15:0] oOptCount, s1oOptCount;
    logic [7:0]  oOverrunCount, s1oOverrunCount;
`endif

    int nAssert = 0;
    int nFail   = 0;

    always #5 CLK = ~CLK;

    mc_pipe_ctrl #(.EXP_N(EXP_N), .CORE_N(CORE_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .iRst_n(iRst_n), .iOptValid(iOptValid),
        .iLaneAddr(iLaneAddr), .iLaneData(iLaneData), .iLaneValid(iLaneValid),
        .iLaneDone(iLaneDone), .iCoreDone(iCoreDone),
        .oStartCalc(oStartCalc), .oStartCores(oStartCores), .oBank(oBank),
        .oBusyCalc(oBusyCalc), .oBusyCores(oBusyCores),
        .oAddr(oAddr), .oData(oData), .oValid(oValid), .oOverrun(oOverrun)
`ifdef MC_PIPE_STATS_EN
        , .oOptCount(oOptCount), .oOverrunCount(oOverrunCount)
`endif
    );

    mc_pipe_ctrl #(.EXP_N(1), .CORE_N(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut1 (
        .CLK(CLK), .iRst_n(iRst_n), .iOptValid(s1Opt),
        .iLaneAddr(s1Addr), .iLaneData(s1Data), .iLaneValid(s1Valid),
        .iLaneDone(s1Done), .iCoreDone(s1CoreDone),
        .oStartCalc(s1oStartCalc), .oStartCores(s1oStartCores), .oBank(s1oBank),
        .oBusyCalc(s1oBusyCalc), .oBusyCores(s1oBusyCores),
        .oAddr(s1oAddr), .oData(s1oData), .oValid(s1oValid), .oOverrun(s1oOverrun)
`ifdef MC_PIPE_STATS_EN
        , .oOptCount(s1oOptCount), .oOverrunCount(s1oOverrunCount)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        iRst_n = 1'b0;
        tick();
        iRst_n = 1'b1;
    endtask

    task automatic test_reset();
        iRst_n = 1'b0; iOptValid = 1'b0; iLaneDone = '0; iCoreDone = '0;
        iLaneValid = '0; iLaneAddr = '0; iLaneData = '0;
        s1Opt = 1'b0; s1Addr = '0; s1Data = '0; s1Valid = '0; s1Done = '0; s1CoreDone = '0;
        tick(); tick();
        nAssert++;
        if ({oStartCalc, oStartCores, oBank, oBusyCalc, oBusyCores, oValid, oOverrun} !== 7'd0) begin
            nFail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {oStartCalc, oStartCores, oBank, oBusyCalc, oBusyCores, oValid, oOverrun});
        end
        nAssert++;
        if (oAddr !== 10'd0 || oData !== 18'd0) begin
            nFail++; $display("FAIL reset_bus: addr %0d data %0d expected 0 0", oAddr, oData);
        end
`ifdef MC_PIPE_STATS_EN
        nAssert++;
        if (oOptCount !== 16'd0 || oOverrunCount !== 8'd0) begin
            nFail++; $display("FAIL reset_stats: %0d %0d expected 0 0", oOptCount, oOverrunCount);
        end
`endif
        iRst_n = 1'b1;
    endtask

    // Option at cycle 0, lane dones at 10/12/15, C_READY at 16, launch visible at 17.
    task automatic test_calc_flow();
        logic expValid, expBusy, expSc, expBank;
        logic [DATA_W-1:0] expData;
        for (int k = 0; k < EXP_N; k++) begin
            iLaneAddr[k*ADDR_W +: ADDR_W] = ADDR_W'(100 + k);
            iLaneData[k*DATA_W +: DATA_W] = DATA_W'(k);
        end
        iLaneValid = '1;
        iOptValid = 1'b1; tick(); iOptValid = 1'b0;      // cycle 1
        nAssert++;
        if (oStartCalc !== 1'b0 || oBusyCalc !== 1'b0) begin
            nFail++; $display("FAIL flow_c1: start %b busy %b expected 0 0", oStartCalc, oBusyCalc);
        end
        tick();                                           // cycle 2
        nAssert++;
        if (oStartCalc !== 1'b1 || oBusyCalc !== 1'b1 || oValid !== 1'b0) begin
            nFail++; $display("FAIL flow_c2: start %b busy %b valid %b expected 1 1 0",
                              oStartCalc, oBusyCalc, oValid);
        end
        for (int c = 2; c <= 17; c++) begin
            iLaneDone[0] = (c == 10);
            iLaneDone[1] = (c == 12);
            iLaneDone[2] = (c == 15);
            tick();                                       // now cycle c+1
            iLaneDone = '0;
            expValid = (c <= 15);
            expData  = DATA_W'((c - 2) % 3);
            expBusy  = (c + 1 <= 15);
            expSc    = (c + 1 == 17);
            expBank  = (c + 1 >= 17);
            nAssert++;
            if (oValid !== expValid) begin
                nFail++; $display("FAIL flow_valid c%0d: got %b expected %b", c + 1, oValid, expValid);
            end
            if (expValid) begin
                nAssert++;
                if (oData !== expData || oAddr !== ADDR_W'(100) + ADDR_W'(expData)) begin
                    nFail++; $display("FAIL flow_data c%0d: data %0d addr %0d expected %0d %0d",
                                      c + 1, oData, oAddr, expData, 100 + expData);
                end
            end
            nAssert++;
            if (oBusyCalc !== expBusy || oStartCalc !== 1'b0) begin
                nFail++; $display("FAIL flow_busy c%0d: busy %b start %b expected %b 0",
                                  c + 1, oBusyCalc, oStartCalc, expBusy);
            end
            nAssert++;
            if (oStartCores !== expSc || oBank !== expBank || oBusyCores !== expBank) begin
                nFail++; $display("FAIL flow_cores c%0d: start %b bank %b busy %b expected %b %b %b",
                                  c + 1, oStartCores, oBank, oBusyCores, expSc, expBank, expBank);
            end
        end
    endtask

    // Second option finishes while cores still busy; launch after last core done.
    task automatic test_pipeline();
        iOptValid = 1'b1; tick(); iOptValid = 1'b0; tick();
        nAssert++;
        if (oStartCalc !== 1'b1 || oBusyCalc !== 1'b1 || oBusyCores !== 1'b1) begin
            nFail++; $display("FAIL pipe_overlap: start %b busyC %b busyK %b expected 1 1 1",
                              oStartCalc, oBusyCalc, oBusyCores);
        end
        iLaneDone = '1; tick(); iLaneDone = '0;
        for (int i = 0; i < 4; i++) begin
            nAssert++;
            if (oBusyCalc !== 1'b0 || oStartCores !== 1'b0 || oBank !== 1'b1) begin
                nFail++; $display("FAIL pipe_hold %0d: busy %b start %b bank %b expected 0 0 1",
                                  i, oBusyCalc, oStartCores, oBank);
            end
            tick();
        end
        iCoreDone = 2'b01; tick(); iCoreDone = '0;
        nAssert++;
        if (oStartCores !== 1'b0 || oBank !== 1'b1) begin
            nFail++; $display("FAIL pipe_partial: start %b bank %b expected 0 1", oStartCores, oBank);
        end
        tick();
        iCoreDone = 2'b10; tick(); iCoreDone = '0;
        nAssert++;
        if (oStartCores !== 1'b1 || oBank !== 1'b0 || oBusyCores !== 1'b1) begin
            nFail++; $display("FAIL pipe_launch: start %b bank %b busy %b expected 1 0 1",
                              oStartCores, oBank, oBusyCores);
        end
        tick();
        nAssert++;
        if (oStartCores !== 1'b0 || oBank !== 1'b0) begin
            nFail++; $display("FAIL pipe_after: start %b bank %b expected 0 0", oStartCores, oBank);
        end
        iCoreDone = '1; tick(); iCoreDone = '0;
        nAssert++;
        if (oBusyCores !== 1'b0) begin
            nFail++; $display("FAIL pipe_coreidle: busy %b expected 0", oBusyCores);
        end
    endtask

    // Two requests during a busy run: one overrun, one further calc run.
    task automatic test_overrun();
        int nOv, nSc, nSk;
        nOv = 0; nSc = 0; nSk = 0;
        do_reset();
        iOptValid = 1'b1; tick(); iOptValid = 1'b0; tick();
        for (int j = 0; j < 30; j++) begin
            iOptValid = (j == 2) || (j == 5);
            iLaneDone = ((j == 8) || (j == 16)) ? 3'b111 : 3'b000;
            iCoreDone = (j == 20) ? 2'b11 : 2'b00;
            tick();
            iOptValid = 1'b0; iLaneDone = '0; iCoreDone = '0;
            nAssert++;
            if (oOverrun !== (j == 5)) begin
                nFail++; $display("FAIL ovr_pulse j%0d: got %b expected %b", j, oOverrun, (j == 5));
            end
            nOv += int'(oOverrun); nSc += int'(oStartCalc); nSk += int'(oStartCores);
        end
        nAssert++;
        if (nOv != 1 || nSc != 1 || nSk != 2) begin
            nFail++; $display("FAIL ovr_counts: ovr %0d startCalc %0d startCores %0d expected 1 1 2",
                              nOv, nSc, nSk);
        end
        nAssert++;
        if (oBusyCalc !== 1'b0) begin
            nFail++; $display("FAIL ovr_idle: busy %b expected 0", oBusyCalc);
        end
    endtask

    // Reset during C_RUN clears everything; stale dones are ignored.
    task automatic test_reset_mid();
        do_reset();
        iOptValid = 1'b1; tick(); iOptValid = 1'b0; tick(); tick();
        iLaneDone = 3'b011; tick(); iLaneDone = '0;
        iRst_n = 1'b0; tick(); iRst_n = 1'b1;
        nAssert++;
        if ({oStartCalc, oStartCores, oBank, oBusyCalc, oBusyCores, oValid, oOverrun} !== 7'd0
            || oAddr !== 10'd0 || oData !== 18'd0) begin
            nFail++; $display("FAIL midrst_outputs: flags %b addr %0d data %0d expected 0",
                              {oStartCalc, oStartCores, oBank, oBusyCalc, oBusyCores, oValid, oOverrun},
                              oAddr, oData);
        end
        iLaneDone = 3'b100; iCoreDone = '1; tick(); iLaneDone = '0; iCoreDone = '0; tick();
        nAssert++;
        if ({oStartCalc, oStartCores, oBusyCalc, oBusyCores} !== 4'd0) begin
            nFail++; $display("FAIL midrst_stale: flags %b expected 0000",
                              {oStartCalc, oStartCores, oBusyCalc, oBusyCores});
        end
        iOptValid = 1'b1; tick(); iOptValid = 1'b0; tick();
        nAssert++;
        if (oStartCalc !== 1'b1) begin
            nFail++; $display("FAIL midrst_restart: start %b expected 1", oStartCalc);
        end
        iLaneDone = 3'b100; tick(); iLaneDone = '0; tick();
        nAssert++;
        if (oBusyCalc !== 1'b1) begin
            nFail++; $display("FAIL midrst_sticky: busy %b expected 1", oBusyCalc);
        end
    endtask

    // EXP_N=1: lane 0 passes straight through with one cycle of latency.
    task automatic test_single_lane();
        do_reset();
        s1Addr = 10'd5; s1Data = 18'd77; s1Valid = 1'b1;
        s1Opt = 1'b1; tick(); s1Opt = 1'b0; tick(); tick();
        nAssert++;
        if (s1oData !== 18'd77 || s1oAddr !== 10'd5 || s1oValid !== 1'b1) begin
            nFail++; $display("FAIL single_pass: data %0d addr %0d valid %b expected 77 5 1",
                              s1oData, s1oAddr, s1oValid);
        end
        s1Data = 18'd78; tick();
        nAssert++;
        if (s1oData !== 18'd78 || s1oValid !== 1'b1) begin
            nFail++; $display("FAIL single_next: data %0d valid %b expected 78 1", s1oData, s1oValid);
        end
        s1Done = 1'b1; tick(); s1Done = 1'b0; tick();
        nAssert++;
        if (s1oValid !== 1'b0 || s1oStartCores !== 1'b1) begin
            nFail++; $display("FAIL single_done: valid %b startCores %b expected 0 1",
                              s1oValid, s1oStartCores);
        end
    endtask

`ifdef MC_PIPE_STATS_EN
    // Three completed options then 301 overrun cycles.
    task automatic test_stats();
        do_reset();
        iLaneDone = '1; iCoreDone = '1;
        for (int n = 0; n < 3; n++) begin
            iOptValid = 1'b1; tick(); iOptValid = 1'b0;
            for (int w = 0; w < 6; w++) tick();
        end
        iLaneDone = '0; iCoreDone = '0;
        nAssert++;
        if (oOptCount !== 16'd3) begin
            nFail++; $display("FAIL stats_opt: got %0d expected 3", oOptCount);
        end
        iOptValid = 1'b1;
        for (int n = 0; n < 302; n++) tick();
        iOptValid = 1'b0; tick();
        nAssert++;
        if (oOverrunCount !== 8'd255 || oOptCount !== 16'd3) begin
            nFail++; $display("FAIL stats_sat: ovr %0d opt %0d expected 255 3", oOverrunCount, oOptCount);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_calc_flow();
        test_pipeline();
        test_overrun();
        test_reset_mid();
        test_single_lane();
`ifdef MC_PIPE_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
